rc4_xor_stream: RTL and testbench
=================================

Name: rc4_xor_stream

Overview:
Downstream consumer of the RC4 keystream core (rc4_new_design).
- Requests a keystream block of NUMS_OF_BYTES bytes from the core and captures it when the core's done rises.
- XORs the captured block byte-by-byte with an incoming plaintext stream, using valid/ready handshakes on both sides.
- On exhausting the block it re-requests the core while en is high.

Parameters:
NUMS_OF_BYTES, 16, keystream bytes per block; byte i is ks_data[i*8 +: 8] and is consumed in ascending i.

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
en  input  1  level: enable block requests
abort  input  1  synchronous abort, one-cycle pulse
ks_data  input  NUMS_OF_BYTES*8  keystream block from the core (data_out)
ks_done  input  1  core done (level, may stay high)
ks_start  output  1  start request to the core
in_data  input  8  plaintext byte
in_valid  input  1  plaintext valid
in_ready  output  1  plaintext accepted when in_valid && in_ready
out_data  output  8  ciphertext byte
out_valid  output  1  ciphertext valid
out_ready  input  1  ciphertext consumed when out_valid && out_ready
block_cnt  output  16  completed blocks, wraps 0xFFFF -> 0
busy  output  1  state != IDLE

Behaviour:
Reset (async, rst_n=0):
- state=IDLE; idx=0; ks_buf=0; done_q=0.
- ks_start=0, in_ready=0, out_valid=0, out_data=0, block_cnt=0, busy=0.

Edge detect: done_q <= ks_done every cycle; done_rise = ks_done && !done_q.

FSM states: IDLE, WAIT, STREAM.
- IDLE: in_ready=0, ks_start=0. If en=1, go to WAIT next cycle.
- WAIT: ks_start=1 (registered, held). On done_rise:
  - ks_buf <= ks_data, idx <= 0, ks_start <= 0, go to STREAM.
  - A ks_done that is already high on entry is ignored; only a rising edge captures.
- STREAM: in_ready = !out_valid || out_ready (combinational, single output register).
  - On an input transfer: out_data <= in_data ^ ks_buf[idx*8 +: 8], out_valid <= 1, idx <= idx+1.
  - When the transfer uses idx == NUMS_OF_BYTES-1: idx <= 0, block_cnt <= block_cnt+1, next state is WAIT if en=1 else IDLE (sampled that cycle).
  - Latency: in_data at cycle t appears on out_data at t+1.

Output register (all states):
- out_valid clears on out_ready when no new transfer occurs in the same cycle.
- With out_valid && out_ready && a new transfer in the same cycle, out_valid stays 1 with the new data (full throughput, 1 byte/clk).
- out_data holds while out_valid=1 && out_ready=0.
- Pending output drains normally after the FSM leaves STREAM.

en handling:
- Deasserting en mid-block does not stop the current block.
- en is only checked in IDLE and at the end of a block.

abort (any state, priority over everything except reset):
- Next cycle: state=IDLE, idx=0, ks_start=0, out_valid=0.
- ks_buf and block_cnt keep their values.

Reset mid-operation: immediate return to the reset values, including dropping ks_start.

Width rules:
- idx is clog2(NUMS_OF_BYTES) bits, minimum 1.
- NUMS_OF_BYTES need not be a power of two; the wrap is an explicit compare, not an overflow.

Test Plan:
1. Reset then en=1 -> ks_start=1 the cycle after IDLE. Model core raises ks_done 5 cycles later with bytes 0x00..0x0F -> ks_start=0 and busy=1. Stream 16×0xFF with out_ready=1 -> out_data 0xFF,0xFE,...,0xF0 back-to-back, block_cnt=1, then ks_start=1 again.
2. Real core with key "Key" (key_length=3), plaintext "Plaintext" -> ciphertext BB F3 16 E8 D9 40 AF 0A D3.
3. Backpressure: out_ready=0 for 4 cycles mid-block -> out_data holds, in_ready=0 while out_valid=1, no byte lost or duplicated, order preserved.
4. ks_done held high from the previous block while re-entering WAIT -> no capture until ks_done falls and rises. Buffer loaded with the new ks_data (0xA5 repeated); 0x00 input -> 0xA5 output.
5. en dropped at byte 7 -> block completes 16 bytes, then IDLE, busy=0, ks_start=0.
6. abort at byte 3 -> next cycle IDLE, out_valid=0, idx=0. Async rst_n pulse during WAIT -> ks_start=0 immediately and block_cnt=0.

Source files
------------

// File: rtl/rc4_xor_stream.sv
// rc4_xor_stream: consumes keystream blocks from the RC4 core and XORs them
// byte-by-byte onto a plaintext stream. It requests a block, captures it on the
// rising edge of the core's done, streams it out, and re-requests while en is high.
module rc4_xor_stream #(
  parameter int NUMS_OF_BYTES = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       en,
  input  logic                       abort,
  input  logic [NUMS_OF_BYTES*8-1:0] ks_data,
  input  logic                       ks_done,
  output logic                       ks_start,
  // Handshakes: a byte moves on a rising clk edge exactly when valid && ready
  // are both high. The source holds valid and data until that edge; ready may
  // depend combinationally on the sink's state. in_ready only rises in STREAM
  // with room in the single output register (or that register draining).
  input  logic [7:0]                 in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [7:0]                 out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [15:0]                block_cnt,
  output logic                       busy,
  output logic [1:0]                 dbg_state
);

  localparam int IDX_W = (NUMS_OF_BYTES > 1) ? $clog2(NUMS_OF_BYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUMS_OF_BYTES - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_STREAM = 2'd2
  } state_t;

  state_t                     state;
  logic [IDX_W-1:0]           idx;
  logic [NUMS_OF_BYTES*8-1:0] ks_buf;
  logic                       done_q;
  logic                       done_rise;
  logic                       in_xfer;
  logic [7:0]                 ks_byte;

  assign done_rise = ks_done && !done_q;
  // An aborting cycle accepts nothing, so no byte is taken and then dropped.
  assign in_ready  = (state == S_STREAM) && !abort && (!out_valid || out_ready);
  assign in_xfer   = in_valid && in_ready;
  assign busy      = (state != S_IDLE);
  assign dbg_state = state;

  // Select the current keystream byte; explicit compare so non-power-of-two sizes work.
  always_comb begin
    ks_byte = 8'h00;
    for (int i = 0; i < NUMS_OF_BYTES; i++) begin
      if (idx == IDX_W'(i)) ks_byte = ks_buf[i*8 +: 8];
    end
  end

  // Control FSM, keystream buffer, output register and block counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      idx       <= '0;
      ks_buf    <= '0;
      done_q    <= 1'b0;
      ks_start  <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= 8'h00;
      block_cnt <= 16'h0000;
    end else begin
      done_q <= ks_done;
      if (abort) begin
        state     <= S_IDLE;
        idx       <= '0;
        ks_start  <= 1'b0;
        out_valid <= 1'b0;
      end else begin
        if (in_xfer) begin
          out_data  <= in_data ^ ks_byte;
          out_valid <= 1'b1;
        end else if (out_ready) begin
          out_valid <= 1'b0;
        end

        case (state)
          S_IDLE: begin
            if (en) begin
              state    <= S_WAIT;
              ks_start <= 1'b1;
            end
          end
          S_WAIT: begin
            // Only a fresh rising edge captures; a done left high is stale.
            if (done_rise) begin
              ks_buf   <= ks_data;
              idx      <= '0;
              ks_start <= 1'b0;
              state    <= S_STREAM;
            end
          end
          S_STREAM: begin
            if (in_xfer) begin
              if (idx == LAST_IDX) begin
                idx       <= '0;
                block_cnt <= block_cnt + 16'd1;
                if (en) begin
                  state    <= S_WAIT;
                  ks_start <= 1'b1;
                end else begin
                  state <= S_IDLE;
                end
              end else begin
                idx <= idx + 1'b1;
              end
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rc4_xor_stream.sv
// Testbench for rc4_xor_stream: a small keystream-core model, a plaintext
// driver, and a scoreboard that predicts every ciphertext byte.
module tb_rc4_xor_stream;

  localparam int NB = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b0;
  logic          abort = 1'b0;
  logic [NB*8-1:0] ks_data = '0;
  logic          ks_done = 1'b0;
  logic          ks_start;
  logic [7:0]    in_data = 8'h00;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [7:0]    out_data;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [15:0]   block_cnt;
  logic          busy;
  logic [1:0]    dbg_state;

  localparam logic [1:0] ST_IDLE = 2'd0, ST_WAIT = 2'd1, ST_STREAM = 2'd2;

  rc4_xor_stream #(.NUMS_OF_BYTES(NB)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .abort(abort),
    .ks_data(ks_data), .ks_done(ks_done), .ks_start(ks_start),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .block_cnt(block_cnt), .busy(busy), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- checking ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- scoreboard ----------------
  logic [7:0]      exp_q[$];
  logic [7:0]      got_log[$];
  logic [NB*8-1:0] cur_ks = '0;
  int              model_idx = 0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("sb_extra_output", 32'd1, 32'd0);
        else check("sb_data", {24'h0, out_data}, {24'h0, exp_q.pop_front()});
        got_log.push_back(out_data);
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(in_data ^ cur_ks[model_idx*8 +: 8]);
        model_idx = (model_idx == NB-1) ? 0 : model_idx + 1;
      end
      if (abort) exp_q.delete();
    end
  end

  // ---------------- driver tasks ----------------
  // Wait (bounded) for the DUT to request a block.
  task automatic wait_ks_start();
    int guard = 0;
    while (!ks_start && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check("ks_start_timeout", {31'h0, ks_start}, 32'd1);
  endtask

  // Core model: after 'delay' cycles present a block and raise done.
  task automatic deliver(input logic [NB*8-1:0] blk, input int delay, input bit hold);
    repeat (delay) @(posedge clk);
    #1;
    ks_data   = blk;
    cur_ks    = blk;
    model_idx = 0;
    ks_done   = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) ks_done = 1'b0;
  endtask

  // Present one plaintext byte and hold it until accepted (bounded).
  task automatic send_byte(input logic [7:0] b);
    int guard = 0;
    in_data  = b;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) check("send_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  function automatic logic [NB*8-1:0] rand_block();
    logic [NB*8-1:0] r;
    for (int i = 0; i < NB; i++) r[i*8 +: 8] = 8'($urandom_range(0, 255));
    return r;
  endfunction

  // ---------------- stimulus ----------------
  logic [NB*8-1:0] blk;
  logic [7:0] pt[9]  = '{8'h50, 8'h6C, 8'h61, 8'h69, 8'h6E, 8'h74, 8'h65, 8'h78, 8'h74};
  logic [7:0] ct[9]  = '{8'hBB, 8'hF3, 8'h16, 8'hE8, 8'hD9, 8'h40, 8'hAF, 8'h0A, 8'hD3};
  logic [7:0] rc4[16] = '{8'hEB, 8'h9F, 8'h77, 8'h81, 8'hB7, 8'h34, 8'hCA, 8'h72,
                          8'hA7, 8'h19, 8'h4A, 8'h17, 8'h2C, 8'h5E, 8'h66, 8'h03};
  logic [7:0] held;
  int t0;
  int log_base;

  initial begin
    // Reset
    repeat (3) @(negedge clk);
    check("rst_ks_start",  {31'h0, ks_start},  32'd0);
    check("rst_in_ready",  {31'h0, in_ready},  32'd0);
    check("rst_out_valid", {31'h0, out_valid}, 32'd0);
    check("rst_out_data",  {24'h0, out_data},  32'd0);
    check("rst_block_cnt", {16'h0, block_cnt}, 32'd0);
    check("rst_busy",      {31'h0, busy},      32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 1: request, capture 00..0F, stream 16 x FF back-to-back
    en = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("t1_ks_start_req", {31'h0, ks_start}, 32'd1);
    for (int i = 0; i < NB; i++) blk[i*8 +: 8] = 8'(i);
    deliver(blk, 5, 1'b0);
    @(negedge clk);
    check("t1_ks_start_low", {31'h0, ks_start}, 32'd0);
    check("t1_busy",         {31'h0, busy},     32'd1);
    check("t1_state_stream", {30'h0, dbg_state}, {30'h0, ST_STREAM});
    @(posedge clk); #1;
    log_base = got_log.size();
    t0 = cyc;
    for (int i = 0; i < NB; i++) send_byte(8'hFF);
    check("t1_throughput_cycles", cyc - t0, NB);
    @(negedge clk);
    check("t1_block_cnt",  {16'h0, block_cnt}, 32'd1);
    check("t1_ks_start_re", {31'h0, ks_start}, 32'd1);
    @(negedge clk);
    check("t1_first_out", {24'h0, got_log[log_base]},      32'h00FF);
    check("t1_last_out",  {24'h0, got_log[log_base+NB-1]}, 32'h00F0);

    // 2: RC4 "Key" keystream on "Plaintext"
    for (int i = 0; i < NB; i++) blk[i*8 +: 8] = rc4[i];
    deliver(blk, 3, 1'b0);
    log_base = got_log.size();
    for (int i = 0; i < 9; i++) send_byte(pt[i]);
    for (int i = 9; i < NB; i++) send_byte(8'h00);
    @(negedge clk);
    @(negedge clk);
    for (int i = 0; i < 9; i++) check($sformatf("t2_ct%0d", i), {24'h0, got_log[log_base+i]}, {24'h0, ct[i]});
    check("t2_block_cnt", {16'h0, block_cnt}, 32'd2);

    // 3: backpressure mid-block (done left high for test 4)
    wait_ks_start();
    @(posedge clk); #1;
    deliver(rand_block(), 2, 1'b1);
    for (int i = 0; i < 5; i++) send_byte(8'($urandom_range(0, 255)));
    out_ready = 1'b0;
    in_data   = 8'($urandom_range(0, 255));
    in_valid  = 1'b1;
    @(negedge clk);
    held = out_data;
    for (int i = 0; i < 4; i++) begin
      check("t3_hold_data",  {24'h0, out_data},  {24'h0, held});
      check("t3_hold_valid", {31'h0, out_valid}, 32'd1);
      check("t3_in_ready",   {31'h0, in_ready},  32'd0);
      if (i < 3) @(negedge clk);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    send_byte(in_data);
    for (int i = 6; i < NB; i++) send_byte(8'($urandom_range(0, 255)));
    @(negedge clk);
    check("t3_block_cnt", {16'h0, block_cnt}, 32'd3);

    // 4: done still high on re-entering WAIT -> no capture until a new rise
    ks_data = {NB{8'hA5}};
    repeat (6) @(negedge clk);
    check("t4_stay_wait", {30'h0, dbg_state}, {30'h0, ST_WAIT});
    check("t4_ks_start",  {31'h0, ks_start},  32'd1);
    @(posedge clk); #1;
    ks_done = 1'b0;
    deliver({NB{8'hA5}}, 2, 1'b0);
    log_base = got_log.size();
    send_byte(8'h00);
    @(negedge clk);
    @(negedge clk);
    check("t4_a5_out", {24'h0, got_log[log_base]}, 32'h00A5);

    // 5: en dropped at byte 7 -> block completes, then IDLE
    @(posedge clk); #1;
    for (int i = 1; i < 7; i++) send_byte(8'h00);
    en = 1'b0;
    for (int i = 7; i < NB; i++) send_byte(8'($urandom_range(0, 255)));
    @(negedge clk);
    check("t5_state_idle", {30'h0, dbg_state}, {30'h0, ST_IDLE});
    check("t5_busy",       {31'h0, busy},      32'd0);
    check("t5_ks_start",   {31'h0, ks_start},  32'd0);
    check("t5_block_cnt",  {16'h0, block_cnt}, 32'd4);
    @(negedge clk);
    check("t5_drained", {31'h0, out_valid}, 32'd0);

    // 6: abort at byte 3, then async reset during WAIT
    @(posedge clk); #1;
    en = 1'b1;
    wait_ks_start();
    @(posedge clk); #1;
    deliver(rand_block(), 2, 1'b0);
    for (int i = 0; i < 3; i++) send_byte(8'($urandom_range(0, 255)));
    out_ready = 1'b0;
    abort     = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    @(negedge clk);
    check("t6_abort_idle",  {30'h0, dbg_state}, {30'h0, ST_IDLE});
    check("t6_abort_valid", {31'h0, out_valid}, 32'd0);
    check("t6_abort_start", {31'h0, ks_start},  32'd0);
    check("t6_abort_cnt",   {16'h0, block_cnt}, 32'd4);
    out_ready = 1'b1;
    wait_ks_start();
    @(posedge clk); #3;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("t6_rst_ks_start", {31'h0, ks_start},  32'd0);
    check("t6_rst_cnt",      {16'h0, block_cnt}, 32'd0);
    check("t6_rst_busy",     {31'h0, busy},      32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    check("sb_empty", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
